uart_signal_rx: RTL

//  Receive-side framer for the signal link: parses byte stream from the UART receiver into 32-bit words.

---
 rtl/uart_signal_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_signal_rx.sv
// uart_signal_rx: receive-side framer for the signal link.
// Parses the UART RX byte stream into 32-bit big-endian words framed as
// SOM, b3, b2, b1, b0, EOM. It presents the last good word with a one-cycle
// strobe, and pulses frame_error when a frame is aborted.
// Optional feature macro: SIGNAL_RX_ERR_CNT_EN adds a saturating
// err_count[15:0] output that counts frame_error pulses.
//
// Handshake: a byte transfers on every rising edge where from_uart_valid and
// from_uart_ready are both high. from_uart_ready is held high whenever the
// block is out of reset, so the block never stalls. from_uart_error qualifies
// only the byte presented in that same cycle.
module uart_signal_rx #(
  parameter logic [7:0]  SOM_BYTE       = 8'h73,
  parameter logic [7:0]  EOM_BYTE       = 8'h65,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  from_uart_data,
  input  logic        from_uart_error,
  input  logic        from_uart_valid,
  output logic        from_uart_ready,
  output logic [31:0] signal,
  output logic        signal_valid,
  output logic        frame_error,
  output logic        busy,
`ifdef SIGNAL_RX_ERR_CNT_EN
  output logic [15:0] err_count,
`endif
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_B3   = 3'd1,
    ST_B2   = 3'd2,
    ST_B1   = 3'd3,
    ST_B0   = 3'd4,
    ST_EOM  = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] shadow;
  logic [31:0] tmo_cnt;
  logic        accept;
  logic        tmo_hit;
  logic        abort;

  assign accept    = from_uart_valid && from_uart_ready;
  // A timeout value of zero disables the inter-byte watchdog entirely.
  assign tmo_hit   = (TIMEOUT_CYCLES != 32'd0) && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
  assign state_dbg = state;

  // Any abort: a UART error inside a frame, a bad EOM byte, or an inter-byte
  // timeout. A byte accepted in the timeout cycle takes priority over the timeout.
  always_comb begin
    abort = 1'b0;
    if (accept) begin
      if (from_uart_error)
        abort = (state != ST_HUNT);
      else
        abort = (state == ST_EOM) && (from_uart_data != EOM_BYTE);
    end else begin
      abort = (state != ST_HUNT) && tmo_hit;
    end
  end

  // Framing FSM, shadow word, inter-byte timeout and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_HUNT;
      shadow          <= 32'd0;
      tmo_cnt         <= 32'd0;
      from_uart_ready <= 1'b0;
      signal          <= 32'd0;
      signal_valid    <= 1'b0;
      frame_error     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      from_uart_ready <= 1'b1;
      signal_valid    <= 1'b0;
      frame_error     <= abort;
      if (accept) begin
        tmo_cnt <= 32'd0;
        if (from_uart_error) begin
          // Corrupted byte: drop it. Inside a frame this also drops the frame.
          if (state != ST_HUNT) begin
            state <= ST_HUNT;
            busy  <= 1'b0;
          end
        end else begin
          case (state)
            ST_HUNT: begin
              if (from_uart_data == SOM_BYTE) begin
                state <= ST_B3;
                busy  <= 1'b1;
              end
            end
            ST_B3: begin
              shadow[31:24] <= from_uart_data;
              state         <= ST_B2;
            end
            ST_B2: begin
              shadow[23:16] <= from_uart_data;
              state         <= ST_B1;
            end
            ST_B1: begin
              shadow[15:8] <= from_uart_data;
              state        <= ST_B0;
            end
            ST_B0: begin
              shadow[7:0] <= from_uart_data;
              state       <= ST_EOM;
            end
            ST_EOM: begin
              if (from_uart_data == EOM_BYTE) begin
                signal       <= shadow;
                signal_valid <= 1'b1;
                state        <= ST_HUNT;
                busy         <= 1'b0;
              end else if (from_uart_data == SOM_BYTE) begin
                // The bad terminator is the start of a new frame.
                state <= ST_B3;
                busy  <= 1'b1;
              end else begin
                state <= ST_HUNT;
                busy  <= 1'b0;
              end
            end
            default: begin
              state <= ST_HUNT;
              busy  <= 1'b0;
            end
          endcase
        end
      end else if (state == ST_HUNT) begin
        tmo_cnt <= 32'd0;
      end else if (tmo_hit) begin
        tmo_cnt <= 32'd0;
        state   <= ST_HUNT;
        busy    <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

`ifdef SIGNAL_RX_ERR_CNT_EN
  // Saturating count of aborted frames, which tracks frame_error edge for edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 16'd0;
    else if (abort && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`endif

endmodule
